samm_param_engine: RTL and testbench
====================================

Name: samm_param_engine

Overview:
Parametrised successor to the fixed 8x8 systolic matrix multiplier top. It is an output-stationary NxN systolic array, built with a generate loop, with internal operand buffers and on-chip input skewing. Matrix dimensions M, K, Ncols are set at run time (each 1..N), and an accumulate mode supports K-tiling. Results leave through a single valid/ready stream instead of N*N parallel output ports. It sits between the operand RAM/loader and the result sink.

Parameters:
N, 8, array edge (PEs = N*N, max M/K/Ncols)
DW, 8, unsigned operand width
AW, 16, accumulator/result width; wraps mod 2^AW
IW, $clog2(N), index width for row/col ports

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous active-high reset
ld_en  in  1  operand buffer write strobe
ld_sel  in  1  0 = A buffer, 1 = B buffer
ld_row  in  IW  buffer row index
ld_col  in  IW  buffer column index
ld_data  in  DW  operand value
dim_m  in  IW+1  rows of A/C (sampled on start)
dim_k  in  IW+1  inner dimension (sampled on start)
dim_n  in  IW+1  columns of B/C (sampled on start)
acc_mode  in  1  1 = keep accumulators from previous run (sampled on start)
start  in  1  launch request, honoured only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last result transfer
cfg_err  out  1  one-cycle pulse on rejected start
rd_valid  out  1  result beat valid
rd_ready  in  1  sink ready
rd_data  out  AW  C[rd_row][rd_col]
rd_row  out  IW  result row index
rd_col  out  IW  result column index
rd_last  out  1  final beat (row M-1, col Ncols-1)

Behaviour:
- Reset (async): FSM=IDLE; busy, done, cfg_err, rd_valid, rd_last = 0; rd_data/rd_row/rd_col = 0; all accumulators, PE pipeline regs and operand buffers = 0. A reset mid-run aborts the run; no done is issued.
- Operand buffers: two NxN DW arrays. ld_en writes on the clock edge only in IDLE; writes in other states are dropped.
- FSM states: IDLE, CLEAR, FEED, DRAIN, OUT.
- IDLE + start:
  - If any dim is 0 or >N: pulse cfg_err for one cycle and stay in IDLE.
  - Otherwise latch dims and acc_mode, then go to CLEAR.
- CLEAR (1 cycle): if acc_mode=0, zero all accumulators; else hold them. Reset feed counter t=0. Go to FEED.
- FEED (M+K+Ncols-2 cycles, t = 0..M+K+Ncols-3):
  - Row i west input = A[i][t-i] if i<M and 0<=t-i<K, else 0.
  - Column j north input = B[t-j][j] if j<Ncols and 0<=t-j<K, else 0.
  - Each PE registers a_out<=a_in and b_out<=b_in (east/south), and sets acc <= acc + a_in*b_in. The product is 2*DW bits, zero-extended or truncated to AW; the sum wraps mod 2^AW.
  - Thus A[i][k] meets B[k][j] at PE(i,j) at t=i+j+k.
- DRAIN (1 cycle): inputs forced to 0 so the final MAC settles. Then go to OUT.
- OUT:
  - Stream C row-major over i<M, j<Ncols. rd_valid=1; rd_data/rd_row/rd_col/rd_last are registered and stable while rd_valid && !rd_ready.
  - A beat transfers on rd_valid && rd_ready and advances the index.
  - After the rd_last transfer: rd_valid=0, done=1 for one cycle, then IDLE.
- Boundaries:
  - PEs outside MxNcols see only zeros and keep their values.
  - start while busy is ignored.
  - start and ld_en in the same IDLE cycle: the write takes effect and the run uses the new value (the first FEED read is at least 2 cycles later).
  - rd_ready may be held low indefinitely with no data loss.
- Latency (zero backpressure): start at cycle 0 -> first rd_valid at cycle M+K+Ncols+1 -> done at cycle M+K+Ncols+1+M*Ncols.

Test Plan:
- Identity: N=8, A=I, B[k][j]=8k+j, dims 8/8/8, rd_ready=1 -> 64 beats equal to B row-major; rd_last on beat 64; first rd_valid at cycle 25; done at cycle 89.
- Non-square: M=2, K=3, Ncols=4, A=[[1,2,3],[4,5,6]], B=all ones -> beats 6,6,6,6,15,15,15,15 with (row,col) (0,0)..(1,3); rd_last on the 8th beat.
- Accumulate: A=all 2, B=all 3, dims 8/8/8, acc_mode=0 -> all results 48. Rerun with acc_mode=1 -> all 96. Rerun with acc_mode=0 -> all 48.
- Wrap: A=B=all 255, K=8 -> every result = 520200 mod 65536 = 61448.
- Backpressure: drop rd_ready for 5 cycles at beat 10 -> rd_data/rd_row/rd_col held; no beat lost or duplicated; 64 beats total.
- Errors/reset:
  - dim_k=0 start -> cfg_err pulses one cycle; busy stays 0.
  - start while busy -> ignored.
  - ld_en during FEED -> buffer unchanged.
  - rst asserted mid-FEED -> outputs 0 immediately; a following full run is correct.

Source files
------------

// File: rtl/samm_param_engine.sv
// samm_param_engine
// Output-stationary NxN systolic matrix multiplier, C = A * B (C is M x Ncols,
// A is M x K, B is K x Ncols). Operands are written into two internal NxN
// buffers while the engine is idle. Each run:
//   1. latches the dimensions,
//   2. clears the accumulators (or keeps them, for K-tiling),
//   3. feeds skewed rows of A from the west and columns of B from the north,
//   4. streams C row-major over a valid/ready port.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   ld_en/ld_sel          buffer write strobe, 0 = A buffer, 1 = B buffer
//   ld_row/ld_col/ld_data buffer write address and value (accepted only in IDLE)
//   dim_m/dim_k/dim_n     run dimensions, each 1..N, sampled on start
//   acc_mode              1 = accumulate onto the previous run's results
//   start                 launch request, honoured only in IDLE
//   busy                  high whenever the engine is not IDLE
//   done                  one-cycle pulse after the last result transfer
//   cfg_err               one-cycle pulse when a start is rejected for bad dimensions
//   rd_valid/rd_ready     result stream handshake
//   rd_data               result value C[rd_row][rd_col]
//   rd_row/rd_col         result indices
//   rd_last               marks the final result beat
module samm_param_engine #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int AW = 16,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic          ld_sel,
    input  logic [IW-1:0] ld_row,
    input  logic [IW-1:0] ld_col,
    input  logic [DW-1:0] ld_data,
    input  logic [IW:0]   dim_m,
    input  logic [IW:0]   dim_k,
    input  logic [IW:0]   dim_n,
    input  logic          acc_mode,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] rd_data,
    output logic [IW-1:0] rd_row,
    output logic [IW-1:0] rd_col,
    output logic          rd_last
);

    // The feed counter must reach M+K+Ncols-3 <= 3N-3.
    localparam int TW = $clog2(3 * N) + 1;
    localparam logic [IW:0] NMAX = (IW + 1)'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_OUT
    } state_t;

    // Full-width product folded into the accumulator width; the sum wraps mod 2^AW.
    function automatic logic [AW-1:0] wrap_prod(input logic [2*DW-1:0] p);
        logic [AW+2*DW-1:0] ext;
        ext = {{AW{1'b0}}, p};
        return ext[AW-1:0];
    endfunction

    state_t state_q, state_d;

    logic [IW:0]   m_q, m_d, k_q, k_d, n_q, n_d;
    logic          accm_q, accm_d;
    logic [TW-1:0] t_q, t_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic [AW-1:0] rd_data_q, rd_data_d;
    logic [IW-1:0] rd_row_q, rd_row_d;
    logic [IW-1:0] rd_col_q, rd_col_d;

    logic [DW-1:0] a_buf_q [N][N];
    logic [DW-1:0] b_buf_q [N][N];

    logic [DW-1:0] west  [N];
    logic [DW-1:0] north [N];
    // Pass-through registers exist only where a neighbour consumes them.
    logic [DW-1:0] a_out   [N][N-1];
    logic [DW-1:0] b_out   [N-1][N];
    logic [AW-1:0] acc_out [N][N];

    logic          dims_ok;
    logic          feed_last;
    logic          xfer;
    logic          pe_en;
    logic          pe_clr;
    logic [TW-1:0] kk_a, kk_b;
    logic [IW-1:0] nrow, ncol;
    logic          col_end;

    assign dims_ok = (dim_m != '0) && (dim_m <= NMAX) &&
                     (dim_k != '0) && (dim_k <= NMAX) &&
                     (dim_n != '0) && (dim_n <= NMAX);

    assign feed_last = (t_q == TW'(m_q) + TW'(k_q) + TW'(n_q) - TW'(3));
    assign xfer      = (state_q == S_OUT) && rd_valid_q && rd_ready;
    assign pe_en     = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign pe_clr    = (state_q == S_CLEAR);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start && dims_ok) state_d = S_CLEAR;
            S_CLEAR: state_d = S_FEED;
            S_FEED:  if (feed_last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_OUT;
            S_OUT:   if (xfer && rd_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs and control next-state ----------------
    always_comb begin
        m_d        = m_q;
        k_d        = k_q;
        n_d        = n_q;
        accm_d     = accm_q;
        t_d        = t_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;
        rd_row_d   = rd_row_q;
        rd_col_d   = rd_col_q;
        col_end    = ({1'b0, rd_col_q} == n_q - 1'b1);
        nrow       = col_end ? rd_row_q + 1'b1 : rd_row_q;
        ncol       = col_end ? '0 : rd_col_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dims_ok) begin
                        m_d    = dim_m;
                        k_d    = dim_k;
                        n_d    = dim_n;
                        accm_d = acc_mode;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: t_d = '0;
            S_FEED:  t_d = t_q + 1'b1;
            S_DRAIN: begin
                // Accumulators are final once FEED ends; present the first beat.
                rd_valid_d = 1'b1;
                rd_row_d   = '0;
                rd_col_d   = '0;
                rd_data_d  = acc_out[0][0];
                rd_last_d  = (m_q == 1) && (n_q == 1);
            end
            S_OUT: begin
                if (xfer) begin
                    if (rd_last_q) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        rd_row_d  = nrow;
                        rd_col_d  = ncol;
                        rd_data_d = acc_out[nrow][ncol];
                        rd_last_d = ({1'b0, nrow} == m_q - 1'b1) &&
                                    ({1'b0, ncol} == n_q - 1'b1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q        <= '0;
            k_q        <= '0;
            n_q        <= '0;
            accm_q     <= 1'b0;
            t_q        <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
        end else begin
            m_q        <= m_d;
            k_q        <= k_d;
            n_q        <= n_d;
            accm_q     <= accm_d;
            t_q        <= t_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
            rd_row_q   <= rd_row_d;
            rd_col_q   <= rd_col_d;
        end
    end

    // ---------------- Operand buffers (writable only while idle) ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_buf_q[i][j] <= '0;
                    b_buf_q[i][j] <= '0;
                end
            end
        end else if (ld_en && (state_q == S_IDLE)) begin
            if (ld_sel) begin
                b_buf_q[ld_row][ld_col] <= ld_data;
            end else begin
                a_buf_q[ld_row][ld_col] <= ld_data;
            end
        end
    end

    // ---------------- Input skew ----------------
    // Row i sees A[i][t-i], column j sees B[t-j][j]; anything outside the
    // active M x K / K x Ncols window is presented as zero.
    always_comb begin
        kk_a = '0;
        kk_b = '0;
        for (int i = 0; i < N; i++) begin
            west[i] = '0;
            kk_a    = t_q - TW'(i);
            if ((state_q == S_FEED) && (TW'(i) < TW'(m_q)) &&
                (t_q >= TW'(i)) && (kk_a < TW'(k_q))) begin
                west[i] = a_buf_q[i][kk_a[IW-1:0]];
            end
        end
        for (int j = 0; j < N; j++) begin
            north[j] = '0;
            kk_b     = t_q - TW'(j);
            if ((state_q == S_FEED) && (TW'(j) < TW'(n_q)) &&
                (t_q >= TW'(j)) && (kk_b < TW'(k_q))) begin
                north[j] = b_buf_q[kk_b[IW-1:0]][j];
            end
        end
    end

    // ---------------- PE array ----------------
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic [DW-1:0]   a_in, b_in;
            logic [2*DW-1:0] prod;
            logic [AW-1:0]   acc_q;

            if (gj == 0) begin : g_aw
                assign a_in = west[gi];
            end else begin : g_an
                assign a_in = a_out[gi][gj-1];
            end
            if (gi == 0) begin : g_bn
                assign b_in = north[gj];
            end else begin : g_bs
                assign b_in = b_out[gi-1][gj];
            end

            assign prod = a_in * b_in;

            // Accumulators are cleared only on a non-accumulating launch.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q <= '0;
                end else if (pe_clr) begin
                    if (!accm_q) acc_q <= '0;
                end else if (pe_en) begin
                    acc_q <= acc_q + wrap_prod(prod);
                end
            end
            assign acc_out[gi][gj] = acc_q;

            // Pass-through registers are flushed every launch so nothing left
            // in flight from a previous run can meet new operands.
            if (gj < N - 1) begin : g_ap
                logic [DW-1:0] a_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                    end else if (pe_clr) begin
                        a_q <= '0;
                    end else if (pe_en) begin
                        a_q <= a_in;
                    end
                end
                assign a_out[gi][gj] = a_q;
            end
            if (gi < N - 1) begin : g_bp
                logic [DW-1:0] b_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        b_q <= '0;
                    end else if (pe_clr) begin
                        b_q <= '0;
                    end else if (pe_en) begin
                        b_q <= b_in;
                    end
                end
                assign b_out[gi][gj] = b_q;
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_data  = rd_data_q;
    assign rd_row   = rd_row_q;
    assign rd_col   = rd_col_q;

endmodule

// File: tb/tb_samm_param_engine.sv
// Testbench for samm_param_engine (N=8, DW=8, AW=16): directed runs with
// hand-computed result tables, stream handshake and latency checks.
module tb_samm_param_engine;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_en = 1'b0;
    logic          ld_sel = 1'b0;
    logic [IW-1:0] ld_row = '0;
    logic [IW-1:0] ld_col = '0;
    logic [DW-1:0] ld_data = '0;
    logic [IW:0]   dim_m = '0;
    logic [IW:0]   dim_k = '0;
    logic [IW:0]   dim_n = '0;
    logic          acc_mode = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, cfg_err, rd_valid, rd_last;
    logic          rd_ready = 1'b1;
    logic [AW-1:0] rd_data;
    logic [IW-1:0] rd_row, rd_col;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] a_m [8][8];
    logic [7:0] b_m [8][8];
    int exp_data [64];
    int got_data [64];
    int got_row  [64];
    int got_col  [64];
    int got_last [64];

    samm_param_engine #(.N(N), .DW(DW), .AW(AW), .IW(IW)) dut (
        .clk(clk), .rst(rst),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n), .acc_mode(acc_mode), .start(start),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_row(rd_row), .rd_col(rd_col), .rd_last(rd_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Writes all of a_m and b_m into the buffers, one write per cycle.
    task automatic load_all();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                ld_en = 1'b1; ld_sel = 1'b0; ld_row = i[2:0]; ld_col = j[2:0];
                ld_data = a_m[i][j];
                @(posedge clk); #1;
                ld_sel = 1'b1; ld_data = b_m[i][j];
                @(posedge clk); #1;
            end
        end
        ld_en = 1'b0;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                a_m[i][j] = (i == j) ? 8'd1 : 8'd0;
                b_m[i][j] = 8'(8 * i + j);
            end
        for (int b = 0; b < 64; b++) exp_data[b] = b;
    endtask

    task automatic set_const(input int av, input int bv, input int res);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                a_m[i][j] = 8'(av);
                b_m[i][j] = 8'(bv);
            end
        for (int b = 0; b < 64; b++) exp_data[b] = res;
    endtask

    // One launch plus full result collection. Called and returns at posedge+1.
    task automatic run(input int m, input int k, input int n, input bit acc,
                       input int stall_at, input int stall_len,
                       input bit poke, input bit ld_with_start, input string nm);
        int t0, cy, nb, fv, dc, stall_cnt;
        dim_m = m[3:0]; dim_k = k[3:0]; dim_n = n[3:0]; acc_mode = acc; start = 1'b1;
        if (ld_with_start) begin
            ld_en = 1'b1; ld_sel = 1'b1; ld_row = 3'd7; ld_col = 3'd7; ld_data = 8'd63;
        end
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; ld_en = 1'b0;
        nb = 0; fv = -1; dc = -1; stall_cnt = 0;
        for (int it = 0; it < 400 && dc < 0; it++) begin
            @(negedge clk);
            cy = cyc - t0;
            if (poke && cy == 5) begin
                start = 1'b1; dim_m = 4'd1; dim_k = 4'd1; dim_n = 4'd1;
                ld_en = 1'b1; ld_sel = 1'b1; ld_row = 3'd7; ld_col = 3'd7; ld_data = 8'd99;
            end else if (poke && cy == 6) begin
                start = 1'b0; ld_en = 1'b0;
                check({nm, " busy_mid"}, busy, 1);
            end
            rd_ready = 1'b1;
            if (rd_valid && nb == stall_at && stall_cnt < stall_len) begin
                rd_ready = 1'b0;
                stall_cnt++;
                check($sformatf("%s hold_data[%0d]", nm, stall_cnt), rd_data, exp_data[nb]);
                check($sformatf("%s hold_col[%0d]", nm, stall_cnt), rd_col, nb % n);
            end
            if (rd_valid && fv < 0) fv = cy;
            if (rd_valid && rd_ready) begin
                if (nb < 64) begin
                    got_data[nb] = rd_data; got_row[nb] = rd_row;
                    got_col[nb]  = rd_col;  got_last[nb] = rd_last;
                end
                nb++;
            end
            if (done) dc = cy;
        end
        rd_ready = 1'b1;
        @(posedge clk); #1;
        check({nm, " done_seen"}, (dc >= 0), 1);
        check({nm, " beats"}, nb, m * n);
        check({nm, " first_valid_cycle"}, fv, m + k + n + 1);
        check({nm, " done_cycle"}, dc, m + k + n + 1 + m * n + stall_len);
        for (int b = 0; b < m * n && b < nb && b < 64; b++) begin
            check($sformatf("%s data[%0d]", nm, b), got_data[b], exp_data[b]);
            check($sformatf("%s row[%0d]", nm, b), got_row[b], b / n);
            check($sformatf("%s col[%0d]", nm, b), got_col[b], b % n);
            check($sformatf("%s last[%0d]", nm, b), got_last[b], (b == m * n - 1) ? 1 : 0);
        end
        check({nm, " done_pulse_width"}, done, 0);
        check({nm, " busy_after"}, busy, 0);
    endtask

    task automatic bad_start(input int m, input int k, input int n, input string nm);
        dim_m = m[3:0]; dim_k = k[3:0]; dim_n = n[3:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, " cfg_err"}, cfg_err, 1);
        check({nm, " busy"}, busy, 0);
        @(posedge clk); #1;
        check({nm, " cfg_err_drop"}, cfg_err, 0);
        check({nm, " busy_still"}, busy, 0);
        check({nm, " rd_valid"}, rd_valid, 0);
    endtask

    initial begin
        int done_flag;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst cfg_err", cfg_err, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_last", rd_last, 0);
        check("rst rd_data", rd_data, 0);
        check("rst rd_row", rd_row, 0);
        check("rst rd_col", rd_col, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity: C = B
        set_identity();
        load_all();
        run(8, 8, 8, 1'b0, -1, 0, 1'b0, 1'b0, "ident");

        // Same run with a start and a B[7][7] write attempted during FEED
        run(8, 8, 8, 1'b0, -1, 0, 1'b1, 1'b0, "busy_poke");

        // Backpressure at beat 10 for 5 cycles
        run(8, 8, 8, 1'b0, 10, 5, 1'b0, 1'b0, "bp");

        // Rejected starts
        bad_start(8, 0, 8, "dimk0");
        bad_start(8, 8, 9, "dimn9");

        // Non-square 2x3 * 3x4
        set_const(0, 1, 0);
        a_m[0][0] = 8'd1; a_m[0][1] = 8'd2; a_m[0][2] = 8'd3;
        a_m[1][0] = 8'd4; a_m[1][1] = 8'd5; a_m[1][2] = 8'd6;
        for (int b = 0; b < 4; b++) exp_data[b] = 6;
        for (int b = 4; b < 8; b++) exp_data[b] = 15;
        load_all();
        run(2, 3, 4, 1'b0, -1, 0, 1'b0, 1'b0, "nonsq");

        // Accumulate sequence
        set_const(2, 3, 48);
        load_all();
        run(8, 8, 8, 1'b0, -1, 0, 1'b0, 1'b0, "acc0a");
        for (int b = 0; b < 64; b++) exp_data[b] = 96;
        run(8, 8, 8, 1'b1, -1, 0, 1'b0, 1'b0, "acc1");
        for (int b = 0; b < 64; b++) exp_data[b] = 48;
        run(8, 8, 8, 1'b0, -1, 0, 1'b0, 1'b0, "acc0b");

        // Wrap: 8 * 255 * 255 mod 65536
        set_const(255, 255, 61448);
        load_all();
        run(8, 8, 8, 1'b0, -1, 0, 1'b0, 1'b0, "wrap");

        // Reset in the middle of FEED
        dim_m = 4'd8; dim_k = 4'd8; dim_n = 4'd8; acc_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst rd_valid", rd_valid, 0);
        check("midrst rd_data", rd_data, 0);
        check("midrst rd_row", rd_row, 0);
        check("midrst done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_flag = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || rd_valid) done_flag = 1;
        end
        check("midrst no_done", done_flag, 0);
        @(posedge clk); #1;

        // Full run after reset; B[7][7] is written in the start cycle itself
        set_identity();
        b_m[7][7] = 8'd0;
        load_all();
        run(8, 8, 8, 1'b0, -1, 0, 1'b0, 1'b1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
